// File: rtl/duck_ctl_pkg.sv
// duck_ctl_pkg: screen geometry, duck sequencer states and a spawn-position helper.
`timescale 1ns/1ps
package duck_ctl_pkg;
    localparam int H_RES      = 1024;
    localparam int V_RES      = 768;
    localparam int DUCK_W     = 64;
    localparam int DUCK_H     = 64;
    localparam int SKY_BOTTOM = 600;
    localparam int X_MAX      = H_RES - DUCK_W;
    localparam int Y_GND      = SKY_BOTTOM - DUCK_H;

    typedef logic signed [11:0] pos_t;

    typedef enum logic [2:0] {IDLE, FLY, HIT_PAUSE, FALL, ESCAPE, DONE} duck_state_t;

    // Fold out-of-range random values back onto the screen instead of clamping, to keep spread.
    function automatic pos_t spawn_x(input logic [9:0] r);
        return (r <= 10'(X_MAX)) ? pos_t'({2'b00, r}) : pos_t'({2'b00, r - 10'd512});
    endfunction
endpackage

// File: rtl/duck_ctl_lfsr16.sv
// lfsr16: 16-bit Galois LFSR (taps 16,14,13,11), one step per clock.
`timescale 1ns/1ps
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= SEED;
        else     q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    end
endmodule

// File: rtl/duck_ctl.sv
// duck_ctl: per-round duck motion and state sequencer (fly, hit pause, fall, escape).
// Define DUCK_CTL_RANDOM_TURN_EN to allow random direction changes every 64th flight frame.
`timescale 1ns/1ps
module duck_ctl
    import duck_ctl_pkg::*;
#(
    parameter int          SPEED        = 4,
    parameter int          FLY_FRAMES   = 300,
    parameter int          PAUSE_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_frame,
    input  logic        start,
    input  logic        shot_hit,
    output logic [10:0] duck_x,
    output logic [10:0] duck_y,
    output logic        duck_show,
    output logic        duck_hit,
    output logic        round_done,
    output logic        duck_killed
);
    localparam pos_t XM  = pos_t'(X_MAX);
    localparam pos_t YG  = pos_t'(Y_GND);
    localparam pos_t SP  = pos_t'(SPEED);
    localparam pos_t SP2 = pos_t'(2 * SPEED);

    duck_state_t state, state_nx;
    pos_t        x, y, dx, dy;
    pos_t        x_nx, y_nx, dx_nx, dy_nx;
    pos_t        sx, sy, fx, fy, fdx, fdy;
    logic [15:0] frame_cnt, frame_nx, frame_inc;
    logic [15:0] pause_cnt, pause_nx, pause_inc;
    logic        killed, killed_nx;
    logic [15:0] l;
    logic        unused_l;

    assign unused_l = ^l[15:11];

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk(clk),
        .rst(rst),
        .q  (l)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            dx        <= '0;
            dy        <= '0;
            frame_cnt <= '0;
            pause_cnt <= '0;
            killed    <= 1'b0;
        end else begin
            state     <= state_nx;
            x         <= x_nx;
            y         <= y_nx;
            dx        <= dx_nx;
            dy        <= dy_nx;
            frame_cnt <= frame_nx;
            pause_cnt <= pause_nx;
            killed    <= killed_nx;
        end
    end

    always_comb begin
        frame_inc = frame_cnt + 16'd1;
        pause_inc = pause_cnt + 16'd1;
        // One flight step with bounce: overshoot is clamped to the edge and that axis reverses.
        sx  = x + dx;
        sy  = y + dy;
        fx  = (sx < 0) ? '0 : (sx > XM) ? XM : sx;
        fy  = (sy < 0) ? '0 : (sy > YG) ? YG : sy;
        fdx = (sx < 0 || sx > XM) ? -dx : dx;
        fdy = (sy < 0 || sy > YG) ? -dy : dy;
`ifdef DUCK_CTL_RANDOM_TURN_EN
        if (frame_inc[5:0] == 6'd0 && frame_inc != '0 && l[0] && fx - fdx >= 0 && fx - fdx <= XM)
            fdx = -fdx;
        if (frame_inc[5:0] == 6'd0 && frame_inc != '0 && l[1] && fy - fdy >= 0 && fy - fdy <= YG)
            fdy = -fdy;
`endif
        state_nx  = state;
        x_nx      = x;
        y_nx      = y;
        dx_nx     = dx;
        dy_nx     = dy;
        frame_nx  = frame_cnt;
        pause_nx  = pause_cnt;
        killed_nx = killed;
        case (state)
            IDLE: if (start) begin
                state_nx  = FLY;
                x_nx      = spawn_x(l[9:0]);
                y_nx      = YG;
                dx_nx     = l[10] ? -SP : SP;
                dy_nx     = -SP;
                frame_nx  = '0;
                killed_nx = 1'b0;
            end
            // A hit freezes the duck even when it lands on the timeout frame.
            FLY: if (shot_hit) begin
                state_nx = HIT_PAUSE;
                pause_nx = '0;
            end else if (new_frame) begin
                x_nx     = fx;
                y_nx     = fy;
                dx_nx    = fdx;
                dy_nx    = fdy;
                frame_nx = frame_inc;
                state_nx = (frame_inc == 16'(FLY_FRAMES)) ? ESCAPE : FLY;
            end
            HIT_PAUSE: if (new_frame) begin
                pause_nx = pause_inc;
                state_nx = (pause_inc == 16'(PAUSE_FRAMES)) ? FALL : HIT_PAUSE;
            end
            FALL: if (new_frame) begin
                y_nx      = (y + SP2 >= YG) ? YG : y + SP2;
                state_nx  = (y + SP2 >= YG) ? DONE : FALL;
                killed_nx = (y + SP2 >= YG) ? 1'b1 : killed;
            end
            ESCAPE: if (new_frame) begin
                dx_nx     = '0;
                y_nx      = (y - SP <= 0) ? '0 : y - SP;
                state_nx  = (y - SP <= 0) ? DONE : ESCAPE;
                killed_nx = (y - SP <= 0) ? 1'b0 : killed;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        duck_x      = x[10:0];
        duck_y      = y[10:0];
        duck_show   = state inside {FLY, HIT_PAUSE, FALL, ESCAPE};
        duck_hit    = state inside {HIT_PAUSE, FALL};
        round_done  = state == DONE;
        duck_killed = killed;
    end
endmodule

// File: tb/tb_duck_ctl.sv
// tb_duck_ctl: randomized rounds of duck_ctl checked every cycle against a behavioural round model.
`timescale 1ns/1ps
module tb_duck_ctl;
    logic        clk = 0, rst = 0, new_frame = 0, start = 0, shot_hit = 0;
    logic [10:0] duck_x, duck_y;
    logic        duck_show, duck_hit, round_done, duck_killed;

    int compared = 0, mismatched = 0;
    bit armed = 0;
    // Model: phase 0 idle, 1 flying, 2 frozen after hit, 3 falling, 4 escaping, 5 round over.
    int m_ph, m_x, m_y, m_dx, m_dy, m_fc, m_pc, m_kill, m_l, m_r;

    duck_ctl dut (
        .clk(clk), .rst(rst), .new_frame(new_frame), .start(start), .shot_hit(shot_hit),
        .duck_x(duck_x), .duck_y(duck_y), .duck_show(duck_show), .duck_hit(duck_hit),
        .round_done(round_done), .duck_killed(duck_killed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            armed = 1; m_ph = 0; m_x = 0; m_y = 0; m_dx = 0; m_dy = 0;
            m_fc = 0; m_pc = 0; m_kill = 0; m_l = 'hACE1;
        end else begin
            case (m_ph)
                0: if (start) begin
                    m_r = m_l & 'h3FF;
                    m_x = (m_r <= 960) ? m_r : m_r - 512;
                    m_y = 536; m_dx = ((m_l >> 10) & 1) ? -4 : 4; m_dy = -4;
                    m_fc = 0; m_kill = 0; m_ph = 1;
                end
                1: if (shot_hit) begin
                    m_ph = 2; m_pc = 0;
                end else if (new_frame) begin
                    m_x += m_dx; m_y += m_dy; m_fc++;
                    if (m_x < 0 || m_x > 960) begin m_x = (m_x < 0) ? 0 : 960; m_dx = -m_dx; end
                    if (m_y < 0 || m_y > 536) begin m_y = (m_y < 0) ? 0 : 536; m_dy = -m_dy; end
                    if (m_fc == 300) m_ph = 4;
                end
                2: if (new_frame) begin
                    m_pc++;
                    if (m_pc == 30) m_ph = 3;
                end
                3: if (new_frame) begin
                    m_y += 8;
                    if (m_y >= 536) begin m_y = 536; m_kill = 1; m_ph = 5; end
                end
                4: if (new_frame) begin
                    m_y -= 4;
                    if (m_y <= 0) begin m_y = 0; m_kill = 0; m_ph = 5; end
                end
                default: m_ph = 0;
            endcase
            m_l = (m_l >> 1) ^ ((m_l & 1) ? 'hB400 : 0);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("x", int'(duck_x), m_x);
            chk("y", int'(duck_y), m_y);
            chk("show", int'(duck_show), int'(m_ph inside {1, 2, 3, 4}));
            chk("hit", int'(duck_hit), int'(m_ph == 2 || m_ph == 3));
            chk("round_done", int'(round_done), int'(m_ph == 5));
            chk("killed", int'(duck_killed), m_kill);
        end
    end

    task automatic tick(input logic nf, input logic st, input logic sh);
        @(negedge clk);
        new_frame = nf; start = st; shot_hit = sh;
    endtask

    // Idle cycle between frames with stray start/shot pulses only where they must be ignored.
    task automatic gap();
        @(negedge clk);
        new_frame = 0;
        start     = (m_ph != 0) && ($urandom_range(0, 9) == 0);
        shot_hit  = (m_ph != 1) && ($urandom_range(0, 9) == 0);
    endtask

    task automatic frame(input logic sh);
        tick(1, 0, sh);
        repeat ($urandom_range(1, 3)) gap();
    endtask

    task automatic finish_round(input int shot, input bit pin);
        int k = 0;
        while (m_ph != 0 && k < 600) begin
            k++;
            tick(1, 0, k == shot);
            if (pin && k == shot) begin
                tick(0, 0, 0);
                chk("hit_next_cycle", int'(duck_hit), 1);
                chk("show_while_hit", int'(duck_show), 1);
            end
            repeat ($urandom_range(1, 3)) gap();
        end
        if (m_ph != 0) begin
            compared++; mismatched++;
            $display("FAIL round_timeout: phase %0d, required 0", m_ph);
        end
    endtask

    task automatic run_round(input int shot, input bit pin);
        tick(0, 1, 0);
        tick(0, 0, 0);
        finish_round(shot, pin);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_x"}, int'(duck_x), 0);
        chk({tag, "_y"}, int'(duck_y), 0);
        chk({tag, "_show"}, int'(duck_show), 0);
        chk({tag, "_hit"}, int'(duck_hit), 0);
        chk({tag, "_done"}, int'(round_done), 0);
        chk({tag, "_killed"}, int'(duck_killed), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        #12.5 rst = 1;
        #1 chk_zero("reset");
        #19 rst = 0;
        repeat (10) frame(0);
        chk_zero("idle_10_frames");

        run_round(0, 0);
        chk("escape_y", int'(duck_y), 0);
        chk("escape_killed", int'(duck_killed), 0);
        chk("escape_show", int'(duck_show), 0);

        run_round(50, 1);
        chk("fall_y", int'(duck_y), 536);
        chk("fall_killed", int'(duck_killed), 1);
        chk("fall_show", int'(duck_show), 0);

        run_round(300, 1);
        chk("tie_killed", int'(duck_killed), 1);

        tick(0, 1, 0);
        tick(0, 0, 0);
        k = 0;
        while (m_ph != 3 && k < 200) begin k++; frame(k == 5); end
        frame(0);
        new_frame = 0; start = 0; shot_hit = 0;
        @(posedge clk);
        #2 rst = 1;
        #1 chk_zero("reset_in_fall");
        @(negedge clk) rst = 0;
        tick(0, 1, 0);
        tick(0, 0, 0);
        chk("fresh_x", int'(duck_x), 624);
        chk("fresh_y", int'(duck_y), 536);
        chk("fresh_show", int'(duck_show), 1);
        tick(1, 0, 0);
        tick(0, 0, 0);
        chk("fresh_step_x", int'(duck_x), 628);
        chk("fresh_step_y", int'(duck_y), 532);
        finish_round(0, 0);

        repeat (4) run_round($urandom_range(1, 450), 0);

        repeat (3) tick(0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
